dcache_ctrl: RTL
================

# dcache_ctrl

Sequencing controller for the four-word data unit of the direct-mapped, write-through, no-write-allocate data cache. It accepts one core request at a time, checks the external tag unit's hit result and then does one of three things: serves read hits from the data unit, refills a missing line with a 4-beat memory burst, or performs write-through. It drives every data-unit control (chip-select, output-enable, byte write-enables, sub-array select, index, write data) and the tag write-enable.

## Interface
- DATAWIDTH, 32, word width
- INDEXWIDTH, 6, line index width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- core_req  in  1  request; sampled only in IDLE
- core_write  in  1  1 = write, 0 = read
- core_index  in  INDEXWIDTH  line index
- core_offset  in  2  word within line
- core_wstrb  in  4  byte enables, active-high
- core_wdata  in  DATAWIDTH  write data
- core_ready  out  1  one-cycle completion pulse
- core_rdata  out  DATAWIDTH  registered read data, valid while core_ready=1
- tag_hit  in  1  tag result, valid only in LOOKUP
- tag_we  out  1  one-cycle pulse that installs tag/valid for addr_index
- mem_req, mem_write  out  1  memory request / direction; held until the final mem_ready
- mem_index  out  INDEXWIDTH; mem_offset  out  2; mem_wstrb  out  4; mem_wdata  out  DATAWIDTH
- mem_ready  in  1  beat accept; for reads, mem_rdata is valid in the same cycle
- mem_rdata  in  DATAWIDTH
- cs_data, oe_data  out  1  data-unit chip-select / output-enable
- web_data  out  4  byte write-enable, active-low
- sel_dataunit_in  out  4  one-hot sub-array write select
- sel_dataunit_out  out  2  sub-array read select
- addr_index  out  INDEXWIDTH; dataunit_in  out  DATAWIDTH
- dataunit_out  in  DATAWIDTH  data-unit read data; synchronous, valid the cycle after the read is issued

## Operation
- States: IDLE, LOOKUP, RD, FILL, WRITE, RESP.
- Default outputs in every state: cs_data=0, oe_data=0, web_data=4'hF, sel_dataunit_in=0, tag_we=0, mem_req=0, core_ready=0.
- IDLE, core_req=1:
  - Latch write, index, offset, wstrb and wdata.
  - Go to LOOKUP.
- LOOKUP:
  - Drive cs_data=1, oe_data=1, addr_index=latched index (speculative read).
  - Read and tag_hit=1: go to RD.
  - Read and tag_hit=0: clear beat counter cnt; go to FILL.
  - Write: latch hit = tag_hit; go to WRITE.
- RD:
  - sel_dataunit_out = offset.
  - core_rdata <= dataunit_out.
  - Go to RESP.
- FILL:
  - Drive mem_req=1, mem_write=0, mem_index=index, mem_offset=cnt.
  - On each mem_ready cycle:
    - Write mem_rdata into the data unit: cs_data=1, sel_dataunit_in=1<<cnt, web_data=4'h0, dataunit_in=mem_rdata.
    - If cnt==offset, core_rdata <= mem_rdata (critical-word capture).
    - cnt increments; 2-bit, 3 wraps to 0.
  - On the beat with cnt==3: tag_we=1 in the same cycle; go to RESP.
  - Beats are always fetched in order 0..3.
- WRITE:
  - Drive mem_req=1, mem_write=1, mem_offset=offset, mem_wstrb=wstrb, mem_wdata=wdata.
  - If hit, on the first WRITE cycle only: cs_data=1, sel_dataunit_in=1<<offset, web_data=~wstrb, dataunit_in=wdata.
  - A write miss never touches the data unit or the tag.
  - On mem_ready go to RESP.
- RESP: core_ready=1; go to IDLE. A core_req in this cycle is ignored; the core re-presents it in IDLE.
- Reset values (the reset cycle and until the first request): state=IDLE, cnt=0, core_rdata=0, core_ready=0, mem_req=0, tag_we=0, cs_data=0, oe_data=0, web_data=4'hF, sel_dataunit_in=0, sel_dataunit_out=0.

## Timing
- Read hit: accept edge t, then LOOKUP at t+1, RD at t+2, core_ready at t+3.
- Read miss:
  - core_ready follows the fourth mem_ready by one cycle.
  - Minimum latency, with mem_ready tied high, is 6 cycles (LOOKUP + 4 FILL + RESP).
- Write: core_ready one cycle after the mem_ready.
- mem_req stays high with stable address/data until mem_ready. For a fill it stays high across all 4 beats; only mem_offset changes.
- mem_ready outside FILL/WRITE is ignored.
- At most one data-unit write per cycle. No read and write in the same cycle.
- Reset mid-FILL or mid-WRITE:
  - Next cycle is IDLE with all outputs at reset values; tag_we is never pulsed, so a partial line stays invalid.
  - Memory must tolerate mem_req dropping without a final mem_ready.

## Test plan
- Reset, then read idx 5 off 2 with tag_hit=0 and mem_ready held high, mem_rdata=32'hA0+cnt -> sel_dataunit_in 1,2,4,8 on consecutive cycles; tag_we on the 4th beat; core_ready 6 cycles after accept; core_rdata=32'hA2.
- Read hit idx 5 off 3, dataunit_out model returns 32'hA3 -> sel_dataunit_out=3 in RD; core_ready at t+3 with core_rdata=32'hA3; mem_req never asserted.
- Write hit idx 5 off 1, wstrb=4'b0011, wdata=32'h1234_5678 -> one cycle with sel_dataunit_in=4'b0010, web_data=4'b1100; mem_write=1 with wstrb 0011; core_ready after mem_ready delayed 3 cycles.
- Write miss idx 9 -> cs_data stays 0 and tag_we stays 0 throughout; memory write issued; core_ready after mem_ready.
- Fill with mem_ready stalls (pattern 1,0,0,1,0,1,1) -> exactly 4 array writes in order 0..3; mem_offset stable during stalls.
- rst_n low after 2 fill beats -> tag_we never pulses; state returns to IDLE; a following read hit behaves as in scenario 2.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Core, tag, memory and data-unit signals of the data-cache sequencer.
// master = the controller, slave = the surrounding core/tag/memory/array side.
`timescale 1ns/1ps
interface dcache_ctrl_if #(
  parameter int DATAWIDTH  = 32,
  parameter int INDEXWIDTH = 6
);
  logic                  core_req;
  logic                  core_write;
  logic [INDEXWIDTH-1:0] core_index;
  logic [1:0]            core_offset;
  logic [3:0]            core_wstrb;
  logic [DATAWIDTH-1:0]  core_wdata;
  logic                  core_ready;
  logic [DATAWIDTH-1:0]  core_rdata;

  logic                  tag_hit;
  logic                  tag_we;

  logic                  mem_req;
  logic                  mem_write;
  logic [INDEXWIDTH-1:0] mem_index;
  logic [1:0]            mem_offset;
  logic [3:0]            mem_wstrb;
  logic [DATAWIDTH-1:0]  mem_wdata;
  logic                  mem_ready;
  logic [DATAWIDTH-1:0]  mem_rdata;

  logic                  cs_data;
  logic                  oe_data;
  logic [3:0]            web_data;
  logic [3:0]            sel_dataunit_in;
  logic [1:0]            sel_dataunit_out;
  logic [INDEXWIDTH-1:0] addr_index;
  logic [DATAWIDTH-1:0]  dataunit_in;
  logic [DATAWIDTH-1:0]  dataunit_out;

  modport master (
    input  core_req, core_write, core_index, core_offset, core_wstrb, core_wdata,
    output core_ready, core_rdata,
    input  tag_hit,
    output tag_we,
    output mem_req, mem_write, mem_index, mem_offset, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata,
    output cs_data, oe_data, web_data, sel_dataunit_in, sel_dataunit_out,
    output addr_index, dataunit_in,
    input  dataunit_out
  );

  modport slave (
    output core_req, core_write, core_index, core_offset, core_wstrb, core_wdata,
    input  core_ready, core_rdata,
    output tag_hit,
    input  tag_we,
    input  mem_req, mem_write, mem_index, mem_offset, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata,
    input  cs_data, oe_data, web_data, sel_dataunit_in, sel_dataunit_out,
    input  addr_index, dataunit_in,
    output dataunit_out
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Sequencer for the write-through, no-write-allocate data cache: read hit 3 cycles, fill >=6, write = mem_ready+1.
// One request in flight; memory stalls via mem_ready, core_req is only sampled in IDLE.
`timescale 1ns/1ps
module dcache_ctrl #(
  parameter int DATAWIDTH  = 32,
  parameter int INDEXWIDTH = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, RD, FILL, WRITE, RESP} state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic                  hit_q, hit_d;
  logic                  first_q, first_d;
  logic [INDEXWIDTH-1:0] index_q, index_d;
  logic [1:0]            offset_q, offset_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [DATAWIDTH-1:0]  wdata_q, wdata_d;
  logic [DATAWIDTH-1:0]  rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      hit_q    <= 1'b0;
      first_q  <= 1'b0;
      index_q  <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      hit_q    <= hit_d;
      first_q  <= first_d;
      index_q  <= index_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.core_rdata = rdata_q;
  assign bus.addr_index = index_q;
  assign bus.mem_index  = index_q;

  // Outputs are forced to their idle values while rst_n is low so a reset
  // landing mid-fill can never complete a beat or install the tag.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    hit_d    = hit_q;
    first_d  = first_q;
    index_d  = index_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    bus.core_ready       = 1'b0;
    bus.tag_we           = 1'b0;
    bus.mem_req          = 1'b0;
    bus.mem_write        = 1'b0;
    bus.mem_offset       = '0;
    bus.mem_wstrb        = '0;
    bus.mem_wdata        = '0;
    bus.cs_data          = 1'b0;
    bus.oe_data          = 1'b0;
    bus.web_data         = 4'hF;
    bus.sel_dataunit_in  = '0;
    bus.sel_dataunit_out = '0;
    bus.dataunit_in      = '0;

    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (bus.core_req) begin
            write_d  = bus.core_write;
            index_d  = bus.core_index;
            offset_d = bus.core_offset;
            wstrb_d  = bus.core_wstrb;
            wdata_d  = bus.core_wdata;
            state_d  = LOOKUP;
          end
        end
        LOOKUP: begin
          bus.cs_data = 1'b1;
          bus.oe_data = 1'b1;
          if (write_q) begin
            hit_d   = bus.tag_hit;
            first_d = 1'b1;
            state_d = WRITE;
          end else if (bus.tag_hit) begin
            state_d = RD;
          end else begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
        RD: begin
          bus.sel_dataunit_out = offset_q;
          rdata_d              = bus.dataunit_out;
          state_d              = RESP;
        end
        FILL: begin
          bus.mem_req    = 1'b1;
          bus.mem_offset = cnt_q;
          if (bus.mem_ready) begin
            bus.cs_data         = 1'b1;
            bus.sel_dataunit_in = 4'b0001 << cnt_q;
            bus.web_data        = 4'h0;
            bus.dataunit_in     = bus.mem_rdata;
            if (cnt_q == offset_q) rdata_d = bus.mem_rdata;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              bus.tag_we = 1'b1;
              state_d    = RESP;
            end
          end
        end
        WRITE: begin
          bus.mem_req    = 1'b1;
          bus.mem_write  = 1'b1;
          bus.mem_offset = offset_q;
          bus.mem_wstrb  = wstrb_q;
          bus.mem_wdata  = wdata_q;
          first_d        = 1'b0;
          // The array copy is updated once, while memory may stall for longer.
          if (hit_q && first_q) begin
            bus.cs_data         = 1'b1;
            bus.sel_dataunit_in = 4'b0001 << offset_q;
            bus.web_data        = ~wstrb_q;
            bus.dataunit_in     = wdata_q;
          end
          if (bus.mem_ready) state_d = RESP;
        end
        RESP: begin
          bus.core_ready = 1'b1;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
